// File: rtl/async_fifo_pkg.sv
// -----------------------------------------------------------------------------
// async_fifo_pkg
// Shared definitions for the asynchronous FIFO pointer controllers.
//   - PTR_EXTRA / ptr_width(): a pointer is one bit wider than the RAM address.
//     The extra bit tells a full FIFO apart from an empty one.
//   - bin2gray / gray2bin: width-agnostic conversions on 32-bit containers.
//     Callers zero-extend their operand and truncate the result.
//     Leading zeros do not change either conversion.
// The write-side full controller and the read-side empty controller both use
// these definitions.
// -----------------------------------------------------------------------------
package async_fifo_pkg;

    // Extra pointer bit beyond the RAM address width (wrap indicator).
    localparam int PTR_EXTRA = 1;

    // Pointer width for a given RAM address width.
    function automatic int ptr_width(input int addrsize);
        return addrsize + PTR_EXTRA;
    endfunction

    // Binary to reflected-binary gray code.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 32'd1);
    endfunction

    // Gray to binary: running XOR prefix starting from the MSB.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// -----------------------------------------------------------------------------
// gray2bin
// Purely combinational gray-to-binary converter of parameterised width.
// Each binary bit is the XOR of all gray bits from the MSB down to that bit.
// The write-side and read-side pointer controllers both instantiate it.
// Ports:
//   gray  in  W  gray-coded value
//   bin   out W  binary equivalent
// -----------------------------------------------------------------------------
module gray2bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    genvar i;
    generate
        for (i = 0; i < W; i++) begin : g_bit
            assign bin[i] = ^gray[W-1:i];
        end
    endgenerate

endmodule

// File: rtl/wptr_full_ctrl.sv
// -----------------------------------------------------------------------------
// wptr_full_ctrl
// Write-domain pointer and flag controller of the asynchronous FIFO.
// It consumes the synchronised gray read pointer and produces:
//   - the binary RAM write address;
//   - the registered gray write pointer;
//   - the full flag, the write-side fill level and a sticky overflow flag.
//
// Optional feature (compile-time macro ASYNC_FIFO_AFULL_EN):
//   When defined, the parameter AFULL_THRESH and the port wafull exist.
//   wafull is the registered flag (next fill level >= AFULL_THRESH).
//
// Ports:
//   wclk       in   1           write clock
//   wrst       in   1           asynchronous active-high reset
//   winc       in   1           write request
//   wq2_rptr   in   ADDRSIZE+1  synchronised gray read pointer
//   wovf_clr   in   1           clears woverflow
//   waddr      out  ADDRSIZE    RAM write address
//   wptr       out  ADDRSIZE+1  registered gray write pointer
//   wfull      out  1           registered full flag
//   wlevel     out  ADDRSIZE+1  registered write-side occupancy, 0..2**ADDRSIZE
//   woverflow  out  1           sticky: a write was attempted while full
//   wafull     out  1           almost full (ASYNC_FIFO_AFULL_EN only)
// -----------------------------------------------------------------------------
module wptr_full_ctrl
    import async_fifo_pkg::*;
#(
    parameter int ADDRSIZE = 4
`ifdef ASYNC_FIFO_AFULL_EN
    ,
    parameter int AFULL_THRESH = (1 << ADDRSIZE) - 1
`endif
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic                wovf_clr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic [ADDRSIZE:0]   wlevel,
`ifdef ASYNC_FIFO_AFULL_EN
    output logic                wafull,
`endif
    output logic                woverflow
);

    localparam int PTR_W = ptr_width(ADDRSIZE);

    logic [PTR_W-1:0] wbin_r;
    logic [PTR_W-1:0] wptr_r;
    logic [PTR_W-1:0] wlevel_r;
    logic             wfull_r;
    logic             wovf_r;

    logic             wpush_s;
    logic [PTR_W-1:0] wbinnext_s;
    logic [PTR_W-1:0] wgraynext_s;
    logic [PTR_W-1:0] rbin_s;
    logic [PTR_W-1:0] wdiff_s;
    logic             wfull_next_s;
    logic             wovf_next_s;

    // Binary view of the synchronised read pointer, used for the fill level.
    gray2bin #(
        .W (PTR_W)
    ) u_rptr_g2b (
        .gray (wq2_rptr),
        .bin  (rbin_s)
    );

    // Next-state logic for the pointers, the full flag, the level and overflow.
    always_comb begin
        wpush_s     = winc & ~wfull_r;
        wbinnext_s  = wbin_r + {{(PTR_W-1){1'b0}}, wpush_s};
        wgraynext_s = PTR_W'(bin2gray(32'(wbinnext_s)));
        // Full when the write pointer has lapped the read pointer by exactly one
        // depth.  In gray code that means the two MSBs differ and the rest match.
        wfull_next_s = (wgraynext_s ==
                        {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
        // Modular subtraction gives the correct level across pointer wrap.
        wdiff_s = wbinnext_s - rbin_s;
        // A rejected write sets overflow.  Set takes priority over clear.
        if (winc & wfull_r) begin
            wovf_next_s = 1'b1;
        end else if (wovf_clr) begin
            wovf_next_s = 1'b0;
        end else begin
            wovf_next_s = wovf_r;
        end
    end

    // State registers.  Reset clears everything immediately.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin_r   <= {PTR_W{1'b0}};
            wptr_r   <= {PTR_W{1'b0}};
            wlevel_r <= {PTR_W{1'b0}};
            wfull_r  <= 1'b0;
            wovf_r   <= 1'b0;
        end else begin
            wbin_r   <= wbinnext_s;
            wptr_r   <= wgraynext_s;
            wlevel_r <= wdiff_s;
            wfull_r  <= wfull_next_s;
            wovf_r   <= wovf_next_s;
        end
    end

`ifdef ASYNC_FIFO_AFULL_EN
    logic wafull_r;
    logic wafull_next_s;

    // Almost-full compare against the next-cycle fill level.
    always_comb begin
        wafull_next_s = (wdiff_s >= PTR_W'(AFULL_THRESH));
    end

    // Almost-full register.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wafull_r <= 1'b0;
        end else begin
            wafull_r <= wafull_next_s;
        end
    end

    assign wafull = wafull_r;
`endif

    assign waddr     = wbin_r[ADDRSIZE-1:0];
    assign wptr      = wptr_r;
    assign wfull     = wfull_r;
    assign wlevel    = wlevel_r;
    assign woverflow = wovf_r;

endmodule

// File: doc/wptr_full_ctrl.md
Name: wptr_full_ctrl

Overview:
- Write-domain pointer and flag controller of the async FIFO.
- Consumes the two-flop-synchronised gray read pointer `wq2_rptr` and produces:
  - the binary write address for the dual-port RAM;
  - the gray write pointer exported to the read-side synchroniser;
  - a registered full flag, write-side fill level and a sticky overflow flag.
- Sits directly downstream of the read-to-write pointer synchroniser, in the `wclk` domain.

Parameters:
- ADDRSIZE, 4, RAM address width; FIFO depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits.
- AFULL_THRESH, 2**ADDRSIZE-1, almost-full level threshold; used only with ASYNC_FIFO_AFULL_EN.

Ports:
- wclk  in  1  write clock
- wrst  in  1  asynchronous active-high reset
- winc  in  1  write request
- wq2_rptr  in  ADDRSIZE+1  synchronised gray read pointer
- wovf_clr  in  1  clears woverflow
- waddr  out  ADDRSIZE  RAM write address (binary pointer LSBs)
- wptr  out  ADDRSIZE+1  gray write pointer, registered, to read-side sync
- wfull  out  1  FIFO full, registered
- wlevel  out  ADDRSIZE+1  write-side occupancy, 0..2**ADDRSIZE
- woverflow  out  1  sticky: write attempted while full
- wafull  out  1  almost full; present only with ASYNC_FIFO_AFULL_EN

Behaviour:
- Reset: one clock (`wclk`); reset is asynchronous and active-high (`wrst`). On `wrst`=1, all registers clear immediately:
  - wbin=0, wptr=0, wfull=0, wlevel=0, woverflow=0, wafull=0.
  - Reset mid-operation discards all pointer state; no write is accepted while wrst=1.
- Accepted write: `wpush = winc & ~wfull`.
  - RAM writes at `waddr` when wpush=1.
  - The pointer advances on the same edge.
- Next-state terms, all ADDRSIZE+1 bits, modulo 2**(ADDRSIZE+1):
  - wbinnext = wbin + wpush
  - wgraynext = (wbinnext>>1) ^ wbinnext
  - wbin, wptr register wbinnext, wgraynext
  - waddr = wbin[ADDRSIZE-1:0]
- Full:
  - wfull_next = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}); registered.
  - Full asserts on the edge accepting the last free slot: zero-cycle lag.
  - Deassertion lags the read by the synchroniser latency (pessimistic, safe).
- Level:
  - rbin_s = gray-to-binary(wq2_rptr), combinational XOR prefix from MSB.
  - wlevel registers (wbinnext - rbin_s), truncated to ADDRSIZE+1 bits.
  - Valid range 0..2**ADDRSIZE; the modular subtraction handles pointer wrap.
- Overflow:
  - woverflow sets when winc=1 and wfull=1.
  - Clears on wovf_clr=1.
  - Simultaneous set and clear: set wins.
  - The rejected write changes no pointer.
- Wrap-around: the pointers roll over from 2**(ADDRSIZE+1)-1 to 0 with no special case.
- Simultaneous write and read-pointer change in the same cycle: both feed next-state logic; no priority needed.

Optional Feature:
- ASYNC_FIFO_AFULL_EN defined:
  - port `wafull` exists; wafull registers (wbinnext - rbin_s) >= AFULL_THRESH.
  - Reset value 0.
- Undefined: the port and logic are absent; AFULL_THRESH is ignored.

Decomposition:
- Shared package `async_fifo_pkg`:
  - pointer-width localparam (ADDRSIZE+1);
  - `bin2gray`/`gray2bin` functions, reused by the read-side empty controller.
- One natural sub-module: `gray2bin` (parameterised width, combinational), also instantiated on the read side.

Test Plan (ADDRSIZE=2, depth 4, wq2_rptr=0 unless stated):
- Reset then idle:
  - wrst pulse mid-cycle -> all outputs 0 immediately, without waiting for a wclk edge.
  - wrst deasserted -> outputs stay at 0.
- Fill:
  - winc=1 for 4 cycles -> wptr 001,011,010,110; waddr 0,1,2,3.
  - wlevel 1,2,3,4; wfull=1 on the 4th edge.
- Overflow:
  - 5th winc while full -> wptr holds 110; woverflow=1.
  - wovf_clr and winc together -> woverflow stays 1.
  - wovf_clr alone -> woverflow clears to 0.
- Drain visibility:
  - From full, set wq2_rptr=001 -> next edge wfull=0, wlevel=3.
  - One winc -> wfull=1, wptr=111.
- Wrap:
  - 8 writes with wq2_rptr tracking to keep the FIFO non-full -> wptr returns to 000, waddr to 0.
  - wlevel correct across the rollover.
- AFULL (macro defined, AFULL_THRESH=3):
  - 3rd write -> wafull=1.
  - wq2_rptr=001 -> wafull=0 next edge.
